// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift units (SLL now, SRL/SRA later).
//   WIDTH          : datapath width in bits
//   SHW            : shift-amount width, $clog2(WIDTH)
//   KW             : width of the stage-index counter that walks SHW-1 down to 0
//   shift_state_t  : handshake/shift FSM states
package shift_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;
  localparam int unsigned KW    = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } shift_state_t;

endpackage

// File: rtl/sll_stage.sv
// One barrel stage of the sequential left shifter.
//   acc      : current partial result
//   k        : stage index; this stage shifts by 2**k
//   bit_en   : shift-amount bit k; when low the value passes through
//   acc_next : acc << 2**k (zero-filled) when bit_en, else acc
module sll_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned KW    = 3
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [KW-1:0]    k,
  input  logic             bit_en,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted  = acc << (32'd1 << k);
    acc_next = bit_en ? shifted : acc;
  end

endmodule

// File: rtl/sll_seq.sv
// Multi-cycle logical left shifter: one barrel stage per clock (2**(SHW-1) down to 1),
// fixed latency of SHW cycles, valid/ready on both the operand and result side.
//   clk, resetn          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, shamt), accepted only in IDLE
//   a, shamt             : value to shift, shift amount
//   out_valid/out_ready  : result handshake; y held stable while out_valid
//   y                    : a << shamt (driven from acc in every state)
//   busy                 : high while shifting or holding a result
module sll_seq #(
  parameter int unsigned WIDTH = shift_pkg::WIDTH,
  parameter int unsigned SHW   = shift_pkg::SHW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  import shift_pkg::*;

  localparam logic [KW-1:0] KStart = KW'(SHW - 1);

  shift_state_t     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   sh_q, sh_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_next;

  sll_stage #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_stage (
    .acc      (acc_q),
    .k        (k_q),
    .bit_en   (sh_q[k_q]),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = a;
          sh_d    = shamt;
          k_d     = KStart;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_next;
        if (k_q == '0) begin
          // Re-arm the index so it idles at its reset value.
          k_d     = KStart;
          state_d = S_DONE;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      k_q     <= KStart;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    y         = acc_q;
  end

endmodule

// File: tb/tb_sll_seq.sv
// Directed self-checking bench for sll_seq: expected results are hand-computed constants.
module tb_sll_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;

  int n_vec;
  int n_err;

  sll_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, present the operand, and return just after the acceptance edge.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [SHW-1:0] sv,
                          input string tag);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check_eq({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = av;
    shamt    = sv;
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles after acceptance until out_valid, then check latency and value.
  task automatic wait_result(input logic [WIDTH-1:0] exp, input string tag);
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'd5);
    check_eq({tag, "_y"}, y, exp);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [SHW-1:0] sv,
                        input logic [WIDTH-1:0] exp, input string tag);
    start_op(av, sv, tag);
    wait_result(exp, tag);
    take_result();
    check_eq({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    shamt     = '0;

    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_y", y, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic vectors.
    run_op(32'h0000_0005, 5'd1,  32'h0000_000A, "v5s1");
    run_op(32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, "ffs4");
    run_op(32'hA5A5_A5A5, 5'd13, 32'hB4B4_A000, "a5s13");
    run_op(32'h1234_5678, 5'd16, 32'h5678_0000, "s16");
    run_op(32'h8765_4321, 5'd31, 32'h8000_0000, "s31");
    run_op(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "s0");

    // Busy flag while shifting.
    start_op(32'h0000_00FF, 5'd8, "bp");
    check_eq("bp_busy_shift", 32'(busy), 32'd1);
    check_eq("bp_in_ready_shift", 32'(in_ready), 32'd0);
    wait_result(32'h0000_FF00, "bp");
    // Backpressure: result must hold for 7 cycles.
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check_eq($sformatf("bp_hold_y%0d", i), y, 32'h0000_FF00);
      check_eq($sformatf("bp_hold_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    take_result();
    check_eq("bp_in_ready_after", 32'(in_ready), 32'd1);
    check_eq("bp_out_valid_after", 32'(out_valid), 32'd0);
    check_eq("bp_busy_after", 32'(busy), 32'd0);

    // in_valid held high with changing operand during SHIFT.
    in_valid = 1'b1;
    a        = 32'h0000_0003;
    shamt    = 5'd2;
    tick();
    for (int i = 0; i < 4; i++) begin
      a     = 32'h1111_1111 * (i + 1);
      shamt = 5'(i + 7);
      tick();
    end
    a = 32'hFFFF_FFFF;
    tick();
    check_eq("hold_valid_latency", 32'(out_valid), 32'd1);
    check_eq("hold_valid_y", y, 32'h0000_000C);
    in_valid = 1'b0;
    take_result();
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("no_second_result%0d", i), 32'(out_valid), 32'd0);
    end

    // Reset during SHIFT cycle 2.
    start_op(32'h0000_0F0F, 5'd20, "rstmid");
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check_eq("rstmid_in_ready", 32'(in_ready), 32'd1);
    check_eq("rstmid_out_valid", 32'(out_valid), 32'd0);
    check_eq("rstmid_y", y, 32'h0);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    run_op(32'h0000_0001, 5'd31, 32'h8000_0000, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
